apb_master: RTL and testbench

- APB initiator (requester) that drives the same pclk-domain APB bus the apb_mem slave responds on.
- Accepts one command at a time on a valid/ready command port and runs the standard SETUP -> ACCESS transfer on APB.
- Returns read data and the error flag on a valid/ready response port.
- Lets RTL blocks (not only testbench drivers) issue APB reads and writes to apb_mem.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_timeout_cnt.sv | 40 ++++
 rtl/apb_master.sv | 160 ++++++++++++++++
 tb/tb_apb_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, default bus widths and the command record
// used by the master and by the environment drivers.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter; done flags the wait cycle that reaches LIMIT.
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, increments saturate at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (inc && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!prst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = inc && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB initiator: one command at a time, SETUP -> ACCESS on the bus, result on a response port.
// Optional ACCESS timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              pselx_q,     pselx_d;
    logic              penable_q,   penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk (pclk),
        .prst (prst),
        .clr  (state_q == SETUP),
        .inc  ((state_q == ACCESS) && !pready),
        .done (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && prst;

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                    pselx_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready on the limit cycle takes priority over the timeout.
                if (pready) begin
                    state_d     = RESP;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata;
                    rsp_err_d   = pslverr;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                pselx_d     = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered bus/response outputs; reset aborts any transfer in flight.
    always_ff @(posedge pclk) begin
        if (!prst) begin
            state_q     <= IDLE;
            paddr_q     <= {ADDR_W{1'b0}};
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small word-memory slave model.
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        prst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        pselx, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_master dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    // Slave memory: reset pattern C0DE_00aa, written on a completed error-free write.
    always @(posedge pclk) begin
        if (!prst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (pselx && penable && pready && pwrite && !pslverr) begin
            mem[paddr] <= pwdata;
        end
    end

    assign prdata = mem[paddr];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input apb_cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick();
        total++; if ({pselx, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin bad++; $display("FAIL rst_ctrl: got=%b exp=00000", {pselx, penable, pwrite, rsp_valid, rsp_err}); end
        total++; if ({paddr, pwdata, rsp_rdata} !== 72'h0) begin bad++; $display("FAIL rst_data: got=%h exp=0", {paddr, pwdata, rsp_rdata}); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready_low: got=%b exp=0", cmd_ready); end
        prst = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready_idle: got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write_read();
        pready = 1'b1;
        issue('{write: 1'b1, addr: 8'h04, wdata: 32'hA5A5_0001});
        total++; if ({pselx, penable, cmd_ready} !== 3'b100) begin bad++; $display("FAIL wr_c1: got=%b exp=100", {pselx, penable, cmd_ready}); end
        total++; if ({paddr, pwrite, pwdata} !== {8'h04, 1'b1, 32'hA5A5_0001}) begin bad++; $display("FAIL wr_bus: got=%h exp=%h", {paddr, pwrite, pwdata}, {8'h04, 1'b1, 32'hA5A5_0001}); end
        tick();
        total++; if ({pselx, penable, rsp_valid} !== 3'b110) begin bad++; $display("FAIL wr_c2: got=%b exp=110", {pselx, penable, rsp_valid}); end
        tick();
        total++; if ({pselx, penable, rsp_valid, rsp_err} !== 4'b0010) begin bad++; $display("FAIL wr_c3: got=%b exp=0010", {pselx, penable, rsp_valid, rsp_err}); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata: got=%h exp=0", rsp_rdata); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL wr_done: got=%b exp=01", {rsp_valid, cmd_ready}); end
        issue('{write: 1'b0, addr: 8'h04, wdata: 32'hFFFF_FFFF});
        total++; if ({pwrite, pwdata} !== 33'h0) begin bad++; $display("FAIL rd_pwdata: got=%h exp=0", {pwrite, pwdata}); end
        tick(); tick();
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A5_0001}) begin bad++; $display("FAIL rd_back: got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hA5A5_0001}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        pready = 1'b0;
        issue('{write: 1'b0, addr: 8'h10, wdata: 32'h0});
        for (int c = 1; c <= 5; c++) begin
            total++; if ({paddr, pselx, penable, rsp_valid} !== {8'h10, 1'b1, (c >= 2), 1'b0}) begin bad++; $display("FAIL ws_c%0d: got=%h exp=%h", c, {paddr, pselx, penable, rsp_valid}, {8'h10, 1'b1, (c >= 2), 1'b0}); end
            pready = (c == 5);
            tick();
        end
        pready = 1'b0;
        total++; if ({rsp_valid, pselx, penable, rsp_rdata} !== {3'b100, 32'hC0DE_0010}) begin bad++; $display("FAIL ws_c6: got=%h exp=%h", {rsp_valid, pselx, penable, rsp_rdata}, {3'b100, 32'hC0DE_0010}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        pready = 1'b1; pslverr = 1'b1;
        issue('{write: 1'b1, addr: 8'h20, wdata: 32'h1111_2222});
        tick(); tick();
        pslverr = 1'b0;
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL err_rsp: got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (mem[8'h20] !== 32'hC0DE_0020) begin bad++; $display("FAIL err_nowrite: got=%h exp=c0de0020", mem[8'h20]); end
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        issue('{write: 1'b0, addr: 8'h04, wdata: 32'h0});
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h08; cmd_wdata = 32'h1234_5678;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            total++; if ({rsp_valid, rsp_rdata, cmd_ready, pselx} !== {1'b1, 32'hA5A5_0001, 2'b00}) begin bad++; $display("FAIL bp_hold%0d: got=%h exp=%h", k, {rsp_valid, rsp_rdata, cmd_ready, pselx}, {1'b1, 32'hA5A5_0001, 2'b00}); end
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if ({rsp_valid, cmd_ready, pselx} !== 3'b010) begin bad++; $display("FAIL bp_idle: got=%b exp=010", {rsp_valid, cmd_ready, pselx}); end
        tick();
        cmd_valid = 1'b0;
        total++; if ({pselx, penable, paddr, pwrite} !== {2'b10, 8'h08, 1'b1}) begin bad++; $display("FAIL bp_next: got=%h exp=%h", {pselx, penable, paddr, pwrite}, {2'b10, 8'h08, 1'b1}); end
        tick(); tick();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (mem[8'h08] !== 32'h1234_5678) begin bad++; $display("FAIL bp_wr: got=%h exp=12345678", mem[8'h08]); end
    endtask

    task automatic test_reset_mid();
        pready = 1'b0;
        issue('{write: 1'b0, addr: 8'h30, wdata: 32'h0});
        tick(); tick();
        total++; if ({pselx, penable} !== 2'b11) begin bad++; $display("FAIL mr_access: got=%b exp=11", {pselx, penable}); end
        prst = 1'b0; tick();
        total++; if ({pselx, penable, rsp_valid, cmd_ready, paddr} !== 12'h0) begin bad++; $display("FAIL mr_abort: got=%h exp=0", {pselx, penable, rsp_valid, cmd_ready, paddr}); end
        prst = 1'b1; #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_idle: got=%b exp=1", cmd_ready); end
        pready = 1'b1;
        issue('{write: 1'b0, addr: 8'h30, wdata: 32'h0});
        tick(); tick();
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hC0DE_0030}) begin bad++; $display("FAIL mr_fresh: got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hC0DE_0030}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        pready = 1'b0;
        issue('{write: 1'b0, addr: 8'h44, wdata: 32'h0});
        tick();
        for (int c = 2; c <= 17; c++) begin
            total++; if ({pselx, penable, rsp_valid} !== 3'b110) begin bad++; $display("FAIL to_wait%0d: got=%b exp=110", c, {pselx, penable, rsp_valid}); end
            tick();
        end
        total++; if ({rsp_valid, rsp_err, pselx, penable, rsp_rdata} !== {4'b1100, 32'h0}) begin bad++; $display("FAIL to_fire: got=%h exp=%h", {rsp_valid, rsp_err, pselx, penable, rsp_rdata}, {4'b1100, 32'h0}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask
`else
    task automatic test_timeout();
        pready = 1'b0;
        issue('{write: 1'b0, addr: 8'h44, wdata: 32'h0});
        tick();
        for (int c = 2; c <= 21; c++) begin
            total++; if ({pselx, penable, rsp_valid} !== 3'b110) begin bad++; $display("FAIL nto_wait%0d: got=%b exp=110", c, {pselx, penable, rsp_valid}); end
            tick();
        end
        pready = 1'b1; tick(); pready = 1'b0;
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hC0DE_0044}) begin bad++; $display("FAIL nto_done: got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hC0DE_0044}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
